// File: rtl/rto_core_mc.sv
// Real-time output core: a timestamped FWFT FIFO whose head is dispatched when the global time
// reaches its timestamp. Define RTO_CORE_ERR_COUNT_EN to add saturating late/overflow counters.
module rto_core_mc #(
    parameter int unsigned TS_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned PROG_FULL  = DEPTH - 16,
    parameter int unsigned LATE_MODE  = 0,
    localparam int unsigned W         = TS_WIDTH + DATA_WIDTH,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LW        = AW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                auto_start,
    input  logic                write,
    input  logic [W-1:0]        fifo_din,
    input  logic [TS_WIDTH-1:0] counter,
    input  logic                err_clear,
    output logic [W-1:0]        rto_out,
    output logic                out_valid,
    output logic                timestamp_error,
    output logic [W-1:0]        timestamp_error_data,
    output logic                overflow_error,
    output logic [W-1:0]        overflow_error_data,
    output logic                full,
    output logic                empty,
    output logic [LW-1:0]       level
`ifdef RTO_CORE_ERR_COUNT_EN
    ,
    output logic [31:0]         late_count,
    output logic [31:0]         overflow_count
`endif
);

    logic [W-1:0]        mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic [TS_WIDTH-1:0] counter_q;
    logic [W-1:0]        rto_out_q;
    logic                out_valid_q;
    logic                ts_err_q, ovf_err_q;
    logic [W-1:0]        ts_err_data_q, ovf_err_data_q;

    logic [W-1:0]        head;
    logic [TS_WIDTH-1:0] head_ts;
    logic                wr_accept, wr_overflow;
    logic                due, late, pop, dispatch;

    assign head    = mem[rd_ptr_q];
    assign head_ts = head[W-1 -: TS_WIDTH];

    assign empty = (level_q == '0);
    assign full  = (level_q >= LW'(PROG_FULL));
    assign level = level_q;

    always_comb begin
        wr_accept   = write && !full && !flush;
        // Writes dropped by flush are discarded silently, not counted as overflow.
        wr_overflow = write && full && !flush;
        due         = head_ts <= counter_q;
        late        = head_ts < counter_q;
        pop         = auto_start && !empty && !flush && due;
        dispatch    = pop && (!late || (LATE_MODE != 0));

        level_d = level_q;
        unique case ({wr_accept, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= fifo_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            counter_q      <= '0;
            rto_out_q      <= '0;
            out_valid_q    <= 1'b0;
            ts_err_q       <= 1'b0;
            ovf_err_q      <= 1'b0;
            ts_err_data_q  <= '0;
            ovf_err_data_q <= '0;
        end else begin
            counter_q   <= counter;
            level_q     <= level_d;
            out_valid_q <= dispatch;

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end

            if (dispatch) begin
                rto_out_q <= head;
            end

            // A new error event in the same cycle as err_clear leaves the flag set.
            if (pop && late) begin
                ts_err_q      <= 1'b1;
                ts_err_data_q <= head;
            end else if (err_clear) begin
                ts_err_q <= 1'b0;
            end

            if (wr_overflow) begin
                ovf_err_q      <= 1'b1;
                ovf_err_data_q <= fifo_din;
            end else if (err_clear) begin
                ovf_err_q <= 1'b0;
            end
        end
    end

    assign rto_out              = rto_out_q;
    assign out_valid            = out_valid_q;
    assign timestamp_error      = ts_err_q;
    assign timestamp_error_data = ts_err_data_q;
    assign overflow_error       = ovf_err_q;
    assign overflow_error_data  = ovf_err_data_q;

`ifdef RTO_CORE_ERR_COUNT_EN
    logic [31:0] late_cnt_q, ovf_cnt_q;
    logic        late_evt;

    assign late_evt = pop && late;

    always_ff @(posedge clk) begin
        if (reset) begin
            late_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (err_clear) begin
                late_cnt_q <= {31'd0, late_evt};
            end else if (late_evt && (late_cnt_q != 32'hFFFF_FFFF)) begin
                late_cnt_q <= late_cnt_q + 32'd1;
            end

            if (err_clear) begin
                ovf_cnt_q <= {31'd0, wr_overflow};
            end else if (wr_overflow && (ovf_cnt_q != 32'hFFFF_FFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 32'd1;
            end
        end
    end

    assign late_count     = late_cnt_q;
    assign overflow_count = ovf_cnt_q;
`endif

endmodule
